// File: rtl/gate_truth_checker.sv
// Sweeps every {a,b} vector onto a 2-input gate under test, samples its output a cycle
// later against TRUTH, and reports mismatch count, first failing vector and pass flag.
module gate_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         PASSES = 1,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_fail_idx,
  output logic             first_fail_valid
);

  localparam int SW = $clog2(PASSES) + 1;
  localparam logic [SW-1:0] LAST_SWEEP = SW'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [SW-1:0] sweep;
  logic          mismatch;

  assign mismatch = dut_out ^ TRUTH[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= 2'd0;
      sweep            <= '0;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
            pass             <= 1'b0;
            idx              <= 2'd0;
            sweep            <= '0;
            busy             <= 1'b1;
            state            <= S_DRIVE;
          end
        end
        S_DRIVE: state <= S_SAMPLE;
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          // Next vector is loaded onto a/b together with the index so DRIVE sees it at once.
          if (idx != 2'd3) begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            state  <= S_DRIVE;
          end else if (sweep != LAST_SWEEP) begin
            idx    <= 2'd0;
            {a, b} <= 2'b00;
            sweep  <= sweep + SW'(1);
            state  <= S_DRIVE;
          end else begin
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(first_fail_valid || mismatch);
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Drives two checker instances (PASSES=1/CNT_W=8 and PASSES=2/CNT_W=3) against modelled gates.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [3:0] gt0, gt1;
  logic a0, b0, busy0, done0, pass0, ffv0;
  logic a1, b1, busy1, done1, pass1, ffv1;
  logic [7:0] err0;
  logic [2:0] err1;
  logic [1:0] ffi0, ffi1;
  logic out0, out1;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign out0 = gt0[{a0, b0}];
  assign out1 = gt1[{a1, b1}];

  gate_truth_checker #(.TRUTH(4'b1000), .PASSES(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(out0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ffi0), .first_fail_valid(ffv0)
  );

  gate_truth_checker #(.TRUTH(4'b1000), .PASSES(2), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(out1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; gt0 = 4'b1000; gt1 = 4'b1000;
    repeat (3) @(negedge clk);
    nvec++;
    if ({a0, b0, busy0, done0, pass0, ffv0, ffi0, err0} !== 16'h0) begin
      nfail++;
      $display("FAIL reset_u0: got %b required 0", {a0, b0, busy0, done0, pass0, ffv0, ffi0, err0});
    end
    nvec++;
    if ({a1, b1, busy1, done1, pass1, ffv1, ffi1, err1} !== 11'h0) begin
      nfail++;
      $display("FAIL reset_u1: got %b required 0", {a1, b1, busy1, done1, pass1, ffv1, ffi1, err1});
    end
    rst = 1'b0;
  endtask

  // One full run on instance sel with gate truth table tt; poke pulses start mid-run and in DONE.
  task automatic run_check(input int sel, input logic [3:0] tt, input bit poke);
    int p, maxc, ones, exp_err, exp_ffi, c_end;
    logic [3:0] diff;
    logic [1:0] oab, eab;
    logic obusy, odone, ebusy, edone, opass, offv;
    logic [1:0] offi;
    int oerr;
    p    = (sel == 0) ? 1 : 2;
    maxc = (sel == 0) ? 255 : 7;
    if (sel == 0) gt0 = tt; else gt1 = tt;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    c_end = 8 * p + 3;
    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      if (sel == 0) begin oab = {a0, b0}; obusy = busy0; odone = done0; end
      else          begin oab = {a1, b1}; obusy = busy1; odone = done1; end
      eab   = (c <= 8 * p) ? 2'((c - 1) % 8 / 2) : 2'b00;
      ebusy = (c <= 8 * p);
      edone = (c == 8 * p + 1);
      nvec++;
      if ({oab, obusy, odone} !== {eab, ebusy, edone}) begin
        nfail++;
        $display("FAIL timeline sel=%0d tt=%b cycle %0d: got ab/busy/done=%b required %b",
                 sel, tt, c, {oab, obusy, odone}, {eab, ebusy, edone});
      end
      if (poke && (c == 3 || c == 8 * p + 1)) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
      end
    end
    if (sel == 0) begin start0 = 1'b0; end else begin start1 = 1'b0; end
    // Reference: mismatching vectors are the set bits of tt ^ TRUTH, repeated once per sweep.
    diff = tt ^ 4'b1000;
    ones = $countones(diff);
    exp_err = (ones * p > maxc) ? maxc : ones * p;
    exp_ffi = 0;
    for (int i = 3; i >= 0; i--) if (diff[i]) exp_ffi = i;
    if (sel == 0) begin oerr = int'(err0); opass = pass0; offv = ffv0; offi = ffi0; end
    else          begin oerr = int'(err1); opass = pass1; offv = ffv1; offi = ffi1; end
    nvec++;
    if (oerr != exp_err) begin
      nfail++;
      $display("FAIL err_count sel=%0d tt=%b: got %0d required %0d", sel, tt, oerr, exp_err);
    end
    nvec++;
    if (opass !== (diff == 4'b0)) begin
      nfail++;
      $display("FAIL pass sel=%0d tt=%b: got %b required %b", sel, tt, opass, diff == 4'b0);
    end
    nvec++;
    if (offv !== (diff != 4'b0)) begin
      nfail++;
      $display("FAIL first_fail_valid sel=%0d tt=%b: got %b required %b", sel, tt, offv, diff != 4'b0);
    end
    if (diff != 4'b0) begin
      nvec++;
      if (offi !== 2'(exp_ffi)) begin
        nfail++;
        $display("FAIL first_fail_idx sel=%0d tt=%b: got %0d required %0d", sel, tt, offi, exp_ffi);
      end
    end
  endtask

  task automatic test_correct_and();
    run_check(0, 4'b1000, 1'b0);
    run_check(1, 4'b1000, 1'b0);
  endtask

  task automatic test_faulty_gates();
    run_check(0, 4'b0000, 1'b0);  // stuck-at-0
    run_check(0, 4'b0111, 1'b0);  // NAND
    run_check(1, 4'b0111, 1'b0);  // NAND, two sweeps: 8 mismatches saturate at 7
    run_check(1, 4'b1111, 1'b0);  // stuck-at-1: 6 mismatches
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_check(0, 4'($urandom_range(0, 15)), 1'b0);
      run_check(1, 4'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  task automatic test_mid_start();
    run_check(0, 4'b0010, 1'b1);
    run_check(1, 4'b1000, 1'b1);
  endtask

  task automatic test_back_to_back();
    gt0 = 4'b1000;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      nvec++;
      if ({busy0, done0} !== {(c % 10 >= 1 && c % 10 <= 8), (c % 10 == 9)}) begin
        nfail++;
        $display("FAIL back_to_back cycle %0d: got busy/done=%b%b required %b%b", c, busy0, done0,
                 (c % 10 >= 1 && c % 10 <= 8), (c % 10 == 9));
      end
    end
    start0 = 1'b0;
    nvec++;
    if ({pass0, err0} !== {1'b1, 8'd0}) begin
      nfail++;
      $display("FAIL back_to_back_result: got pass=%b err=%0d required pass=1 err=0", pass0, err0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    gt0 = 4'b0111;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({a0, b0, busy0, done0, pass0, ffv0, ffi0, err0} !== 16'h0) begin
      nfail++;
      $display("FAIL reset_midrun: got %b required 0", {a0, b0, busy0, done0, pass0, ffv0, ffi0, err0});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++;
      if ({busy0, done0} !== 2'b00) begin
        nfail++;
        $display("FAIL reset_hold cycle %0d: got busy/done=%b%b required 00", c, busy0, done0);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nvec++;
      if (done0 !== 1'b0) begin
        nfail++;
        $display("FAIL abandoned_done cycle %0d: got done=%b required 0", c, done0);
      end
    end
    run_check(0, 4'b1000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_correct_and();
    test_faulty_gates();
    test_random();
    test_mid_start();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
